// File: rtl/seq_div.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Uses a load rising-edge start and a ready_out handshake; flags divide-by-zero.
module seq_div #(
    parameter int unsigned N = 4
) (
    input  logic           clk,
    input  logic           rst_a,
    input  logic           load,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           ready_out,
    output logic           div_by_zero
);

    localparam int unsigned CntW = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(2 * N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic            load_q;
    logic [2*N-1:0]  d_q, d_d;
    logic [N-1:0]    v_q, v_d;
    logic [N:0]      r_q, r_d;
    logic [2*N-1:0]  q_q, q_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2*N-1:0]  quotient_q, quotient_d;
    logic [N-1:0]    remainder_q, remainder_d;
    logic            ready_q, ready_d;
    logic            dbz_q, dbz_d;

    logic            start;
    logic [N:0]      r_shift;
    logic            fits;
    logic [N:0]      r_iter;
    logic [2*N-1:0]  q_iter;

    // One restoring step; R' is one bit wider than V so the compare never overflows.
    always_comb begin
        start   = load & ~load_q;
        r_shift = {r_q[N-1:0], d_q[2*N-1]};
        fits    = (r_shift >= {1'b0, v_q});
        r_iter  = fits ? (r_shift - {1'b0, v_q}) : r_shift;
        q_iter  = {q_q[2*N-2:0], fits};
    end

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        v_d         = v_q;
        r_d         = r_q;
        q_d         = q_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        ready_d     = ready_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_d = StBusy;
                        d_d     = dividend;
                        v_d     = divisor;
                        r_d     = '0;
                        q_d     = '0;
                        cnt_d   = '0;
                        ready_d = 1'b0;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d     = StDone;
                        quotient_d  = '1;
                        remainder_d = '0;
                        ready_d     = 1'b1;
                        dbz_d       = 1'b1;
                    end
                end
            end
            StBusy: begin
                d_d   = d_q << 1;
                r_d   = r_iter;
                q_d   = q_iter;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d     = StDone;
                    quotient_d  = q_iter;
                    remainder_d = r_iter[N-1:0];
                    ready_d     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q     <= StIdle;
            load_q      <= 1'b0;
            d_q         <= '0;
            v_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            ready_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_q      <= load;
            d_q         <= d_d;
            v_q         <= v_d;
            r_q         <= r_d;
            q_q         <= q_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            ready_q     <= ready_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign ready_out   = ready_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div (N=4): directed table, handshake corner cases,
// and a full sweep of dividend/divisor pairs.
module tb_seq_div;

    localparam int unsigned N = 4;

    logic           clk;
    logic           rst_a;
    logic           load;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           ready_out;
    logic           div_by_zero;

    int checks;
    int failures;

    seq_div #(.N(N)) dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .load       (load),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .ready_out  (ready_out),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dd;
        logic [3:0] dv;
        logic [7:0] eq;
        logic [3:0] er;
        logic       edbz;
        int         elat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start a divide on a fresh load rising edge; lat = edges after the start edge until ready.
    task automatic do_div(input logic [7:0] dd, input logic [3:0] dv, output int lat);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        load     = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!ready_out && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        checks   = 0;
        failures = 0;
        rst_a    = 1'b1;
        load     = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0] = '{dd: 8'd200, dv: 4'd7,  eq: 8'd28,  er: 4'd4,  edbz: 1'b0, elat: 8};
        vecs[1] = '{dd: 8'd255, dv: 4'd1,  eq: 8'd255, er: 4'd0,  edbz: 1'b0, elat: 8};
        vecs[2] = '{dd: 8'd225, dv: 4'd15, eq: 8'd15,  er: 4'd0,  edbz: 1'b0, elat: 8};
        vecs[3] = '{dd: 8'd7,   dv: 4'd9,  eq: 8'd0,   er: 4'd7,  edbz: 1'b0, elat: 8};
        vecs[4] = '{dd: 8'd100, dv: 4'd0,  eq: 8'd255, er: 4'd0,  edbz: 1'b1, elat: 0};
        vecs[5] = '{dd: 8'd50,  dv: 4'd6,  eq: 8'd8,   er: 4'd2,  edbz: 1'b0, elat: 8};
        vecs[6] = '{dd: 8'd0,   dv: 4'd5,  eq: 8'd0,   er: 4'd0,  edbz: 1'b0, elat: 8};
        vecs[7] = '{dd: 8'd254, dv: 4'd15, eq: 8'd16,  er: 4'd14, edbz: 1'b0, elat: 8};
        vecs[8] = '{dd: 8'd15,  dv: 4'd15, eq: 8'd1,   er: 4'd0,  edbz: 1'b0, elat: 8};
        vecs[9] = '{dd: 8'd128, dv: 4'd3,  eq: 8'd42,  er: 4'd2,  edbz: 1'b0, elat: 8};

        #12;
        check("reset_quotient", 32'(quotient), 0);
        check("reset_remainder", 32'(remainder), 0);
        check("reset_ready", 32'(ready_out), 0);
        check("reset_dbz", 32'(div_by_zero), 0);
        #13;
        rst_a = 1'b0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            do_div(vecs[i].dd, vecs[i].dv, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].elat));
            check($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].eq));
            check($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].er));
            check($sformatf("vec%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].edbz));
            check($sformatf("vec%0d_ready", i), 32'(ready_out), 1);
            if (i == 0) begin
                // Load still held high: must not retrigger
                for (int c = 0; c < 4; c++) begin
                    @(posedge clk);
                    #1;
                    check("held_load_ready", 32'(ready_out), 1);
                end
                check("held_load_quotient", 32'(quotient), 28);
            end
        end

        // Second load pulse at cnt=3 with different operands must be ignored
        do_div(8'd100, 4'd0, lat);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        load     = 1'b1;
        @(posedge clk);                 // edge k
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 4'd6;
        load     = 1'b1;                // sampled at edge k+4 with cnt=3
        repeat (4) @(posedge clk);      // edges k+4..k+7
        #1;
        check("ignore_ready_k7", 32'(ready_out), 0);
        @(posedge clk);                 // edge k+8
        #1;
        check("ignore_ready_k8", 32'(ready_out), 1);
        check("ignore_quotient", 32'(quotient), 28);
        check("ignore_remainder", 32'(remainder), 4);
        check("ignore_dbz", 32'(div_by_zero), 0);

        // Reset mid-divide
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 4'd7;
        load     = 1'b1;
        @(posedge clk);                 // edge k
        repeat (4) @(posedge clk);      // cnt=4 after edge k+4
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("abort_quotient", 32'(quotient), 0);
        check("abort_remainder", 32'(remainder), 0);
        check("abort_ready", 32'(ready_out), 0);
        check("abort_dbz", 32'(div_by_zero), 0);
        load = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_result", 32'(ready_out), 0);
        do_div(8'd50, 4'd6, lat);
        check("after_abort_latency", 32'(lat), 8);
        check("after_abort_quotient", 32'(quotient), 8);
        check("after_abort_remainder", 32'(remainder), 2);

        // Full sweep against the arithmetic reference
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                do_div(8'(a), 4'(b), lat);
                check($sformatf("sweep_lat_%0d_%0d", a, b), 32'(lat), 8);
                check($sformatf("sweep_q_%0d_%0d", a, b), 32'(quotient), 32'(a / b));
                check($sformatf("sweep_r_%0d_%0d", a, b), 32'(remainder), 32'(a % b));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
